wb_stage: RTL

- Write-back end of the pipeline: the writer side of the regfile read path used by ID.
- Accepts results from the execute/memory side through a valid/ready handshake and buffers them in a small FIFO.
- Drives the regfile write port, retiring one entry per granted cycle.
- Supplies forwarding data to ID for register writes that are still pending.

---
 rtl/wb_stage_pkg.sv | 10 +
 rtl/wb_fifo.sv | 66 ++++++
 rtl/wb_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// Shared widths and constants for the write-back stage.
package wb_stage_pkg;

    localparam int unsigned RADDR_WIDTH = 5;
    localparam int unsigned RDATA_WIDTH = 32;
    localparam int unsigned WB_DEPTH    = 2;

    localparam logic [RADDR_WIDTH-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// Generic pending-write FIFO; exposes entries ordered oldest-first so the
// owner can run an age-ordered compare across all occupied slots.
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 37
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty,
    output logic [DEPTH-1:0][W-1:0]      ord_data,
    output logic [DEPTH-1:0]             ord_valid
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [CW-1:0] cnt;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            cnt      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail_ptr] <= wdata;
                tail_ptr      <= tail_ptr + PW'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign count = cnt;
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign head  = empty ? '0 : mem[head_ptr];

    // Slot i is the i-th oldest entry; higher index means newer.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ord_data[i]  = mem[head_ptr + PW'(i)];
            ord_valid[i] = (CW'(i) < cnt);
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: filters results, queues pending regfile writes, drains
// them on grant and forwards pending data to ID. Option: WB_BYPASS_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH,
    parameter int unsigned AW    = RADDR_WIDTH,
    parameter int unsigned DW    = RDATA_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic                   reg_we_i,
    input  logic [AW-1:0]          reg_waddr_i,
    input  logic [DW-1:0]          reg_wdata_i,
    output logic                   we_o,
    output logic [AW-1:0]          waddr_o,
    output logic [DW-1:0]          wdata_o,
    input  logic                   wr_gnt_i,
    input  logic [AW-1:0]          raddr1_i,
    input  logic [AW-1:0]          raddr2_i,
    output logic                   fwd1_hit_o,
    output logic [DW-1:0]          fwd1_data_o,
    output logic                   fwd2_hit_o,
    output logic [DW-1:0]          fwd2_data_o,
    output logic [$clog2(DEPTH):0] pending_o
);

    localparam int unsigned W = AW + DW;

    logic                    keep;
    logic                    accept;
    logic                    bypass;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [W-1:0]            head;
    logic [DEPTH-1:0][W-1:0] ord_data;
    logic [DEPTH-1:0]        ord_valid;

    assign ready_o = !full && !rst_i;
    assign accept  = valid_i && ready_o;
    assign keep    = reg_we_i && (reg_waddr_i != AW'(ZERO_REG));

`ifdef WB_BYPASS_EN
    // An empty queue with the port granted lets the beat go straight through.
    assign bypass = accept && keep && empty && wr_gnt_i;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && keep && !bypass;
    assign pop  = !empty && wr_gnt_i;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .pop       (pop),
        .wdata     ({reg_waddr_i, reg_wdata_i}),
        .head      (head),
        .count     (pending_o),
        .full      (full),
        .empty     (empty),
        .ord_data  (ord_data),
        .ord_valid (ord_valid)
    );

    // Regfile write port driven from the head entry (or the bypassed beat).
    always_comb begin
        we_o    = !empty;
        waddr_o = head[W-1:DW];
        wdata_o = head[DW-1:0];
        if (bypass) begin
            we_o    = 1'b1;
            waddr_o = reg_waddr_i;
            wdata_o = reg_wdata_i;
        end
    end

    // Oldest-to-newest scan so the last match (newest) wins.
    function automatic logic [DW:0] fwd_lookup(
        input logic [AW-1:0]          raddr,
        input logic [DEPTH-1:0]       ov,
        input logic [DEPTH-1:0][W-1:0] od,
        input logic                   byp,
        input logic [AW-1:0]          baddr,
        input logic [DW-1:0]          bdata
    );
        logic [DW:0] r;
        r = '0;
        if (raddr != AW'(ZERO_REG)) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ov[i] && (od[i][W-1:DW] == raddr)) begin
                    r = {1'b1, od[i][DW-1:0]};
                end
            end
            if (byp && (baddr == raddr)) begin
                r = {1'b1, bdata};
            end
        end
        return r;
    endfunction

    always_comb begin
        {fwd1_hit_o, fwd1_data_o} = fwd_lookup(raddr1_i, ord_valid, ord_data,
                                               bypass, reg_waddr_i, reg_wdata_i);
        {fwd2_hit_o, fwd2_data_o} = fwd_lookup(raddr2_i, ord_valid, ord_data,
                                               bypass, reg_waddr_i, reg_wdata_i);
    end

endmodule
